// File: rtl/vec_cache_dirty_flush.sv
`default_nettype none
// ============================================================================
// vec_cache_dirty_flush : walks the dirty array, writes back and cleans lines
// Revision: 1.0
// ============================================================================
module vec_cache_dirty_flush #(
   parameter int INDEX_WIDTH = 6,
   parameter int WAY_NUM     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_req,
   output logic                        flush_busy,
   output logic                        flush_done,
   input  logic [WAY_NUM-1:0]          tag_dirty [2**INDEX_WIDTH],
   output logic                        wb_req_vld,
   input  logic                        wb_req_rdy,
   output logic [INDEX_WIDTH-1:0]      wb_req_idx,
   output logic [WAY_NUM-1:0]          wb_req_way_oh,
   input  logic                        wb_ack_vld,
   output logic                        dirty_clean,
   output logic [2**INDEX_WIDTH-1:0]   clean_idx_oh,
   output logic [WAY_NUM-1:0]          clean_way_oh
);

   localparam int                        c_set_num  = 2**INDEX_WIDTH;
   localparam logic [INDEX_WIDTH-1:0]    c_last_idx = '1;
   localparam logic [INDEX_WIDTH-1:0]    c_idx_one  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WAY_NUM-1:0]        c_way_one  = {{(WAY_NUM-1){1'b0}}, 1'b1};
   localparam logic [c_set_num-1:0]      c_set_one  = {{(c_set_num-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SCAN     = 3'd1,
      ST_REQ      = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_CLEAN    = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   state_t                    r_state;
   logic [INDEX_WIDTH-1:0]    r_idx;
   logic [WAY_NUM-1:0]        r_way_oh;
   logic [WAY_NUM-1:0]        w_set_dirty;
   logic [WAY_NUM-1:0]        w_lowest_oh;

   // Two's-complement trick isolates the lowest dirty way of the current set.
   assign w_set_dirty = tag_dirty[r_idx];
   assign w_lowest_oh = w_set_dirty & (~w_set_dirty + c_way_one);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_way_oh      <= '0;
         flush_busy    <= 1'b0;
         flush_done    <= 1'b0;
         wb_req_vld    <= 1'b0;
         wb_req_idx    <= '0;
         wb_req_way_oh <= '0;
         dirty_clean   <= 1'b0;
         clean_idx_oh  <= '0;
         clean_way_oh  <= '0;
      end else begin
         flush_done   <= 1'b0;
         dirty_clean  <= 1'b0;
         clean_idx_oh <= '0;
         clean_way_oh <= '0;
         case (r_state)
            ST_IDLE: begin
               if (flush_req) begin
                  r_state    <= ST_SCAN;
                  r_idx      <= '0;
                  flush_busy <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (|w_set_dirty) begin
                  r_state       <= ST_REQ;
                  r_way_oh      <= w_lowest_oh;
                  wb_req_vld    <= 1'b1;
                  wb_req_idx    <= r_idx;
                  wb_req_way_oh <= w_lowest_oh;
               end else if (r_idx == c_last_idx) begin
                  r_state    <= ST_DONE;
                  flush_done <= 1'b1;
               end else begin
                  r_idx <= r_idx + c_idx_one;
               end
            end
            ST_REQ: begin
               if (wb_req_rdy) begin
                  r_state       <= ST_WAIT_ACK;
                  wb_req_vld    <= 1'b0;
                  wb_req_idx    <= '0;
                  wb_req_way_oh <= '0;
               end
            end
            ST_WAIT_ACK: begin
               if (wb_ack_vld) begin
                  r_state      <= ST_CLEAN;
                  dirty_clean  <= 1'b1;
                  clean_idx_oh <= c_set_one << r_idx;
                  clean_way_oh <= r_way_oh;
               end
            end
            // Rescan the same set: the clean lands in the array at this edge.
            ST_CLEAN: begin
               r_state <= ST_SCAN;
            end
            ST_DONE: begin
               r_state    <= ST_IDLE;
               flush_busy <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               flush_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
